// File: rtl/vend_controller.sv
// ---------------------------------------------------------------------------
// vend_controller
//
// Transaction stage that sits after the coin credit accumulator. It takes a
// snapshot of the accumulated balance when a product is selected or a refund
// is requested. It compares that balance with the product price and strobes
// dispense for one cycle. It then pays the remainder back coin by coin over a
// valid/ack handshake. Last, it strobes credit_clear so the credit stage
// zeroes its balance.
//
// Parameters
//   PRICE0..PRICE3  price of items 0..3 in currency units (0..255)
//
// Ports
//   clk            single clock; all state changes on the rising edge
//   reset_n        asynchronous, active-low reset
//   balance        current credit from the credit stage (unsigned, 8 bit)
//   select_valid   one-cycle request to buy item `select`
//   select         item index 0..3
//   cancel         one-cycle refund request (wins over select_valid)
//   change_ack     coin-return mechanism accepted the presented coin
//   busy           high in every state except IDLE
//   dispense       one-cycle strobe: release item dispense_item
//   dispense_item  item index while dispense is high, else 0
//   insufficient   one-cycle strobe: selection rejected, balance kept
//   change_valid   change_coin holds a coin to return
//   change_coin    one-hot coin code (5,10,20,50,100); 0 when not valid
//   credit_clear   one-cycle strobe: credit stage clears its balance
// ---------------------------------------------------------------------------
module vend_controller #(
    parameter int PRICE0 = 15,
    parameter int PRICE1 = 25,
    parameter int PRICE2 = 50,
    parameter int PRICE3 = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] balance,
    input  logic       select_valid,
    input  logic [1:0] select,
    input  logic       cancel,
    input  logic       change_ack,
    output logic       busy,
    output logic       dispense,
    output logic [1:0] dispense_item,
    output logic       insufficient,
    output logic       change_valid,
    output logic [4:0] change_coin,
    output logic       credit_clear
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_CLEAR    = 3'd4
    } state_t;

    localparam int NUM_ITEMS = 4;
    localparam int NUM_COINS = 5;

    localparam int PRICES [NUM_ITEMS] = '{PRICE0, PRICE1, PRICE2, PRICE3};

    // Coin values in ascending order. Bit i of the one-hot coin code
    // corresponds to DENOM[i].
    localparam logic [7:0] DENOM [NUM_COINS] = '{8'd5, 8'd10, 8'd20, 8'd50, 8'd100};

    localparam logic [7:0] MIN_COIN = 8'd5;

    state_t     state_reg,        state_next;
    logic [7:0] remaining_reg,    remaining_next;
    logic [1:0] item_reg,         item_next;
    logic       insufficient_reg, insufficient_next;

    // ------------------------------------------------------------------
    // Price lookup for the latched item
    // ------------------------------------------------------------------
    logic [7:0] price_tbl [NUM_ITEMS];
    logic [7:0] price_sel;

    generate
        for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_price
            assign price_tbl[gi] = 8'(PRICES[gi]);
        end
    endgenerate

    assign price_sel = price_tbl[item_reg];

    // ------------------------------------------------------------------
    // Greedy coin selection.
    // The fits vector is a thermometer code: bit i is set when the
    // remainder covers DENOM[i]. Its highest set bit is the largest coin
    // that still fits. Masking each bit with the inverse of the bit above
    // it leaves only that highest bit, so the result is one-hot.
    // ------------------------------------------------------------------
    logic [NUM_COINS-1:0] fits;
    logic [NUM_COINS-1:0] coin_onehot;
    logic [7:0]           coin_term [NUM_COINS];
    logic [7:0]           coin_value;
    logic                 coin_avail;
    logic [7:0]           remaining_after;

    generate
        for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_coin
            assign fits[gi]      = (remaining_reg >= DENOM[gi]);
            assign coin_term[gi] = coin_onehot[gi] ? DENOM[gi] : 8'd0;
        end
    endgenerate

    assign coin_onehot = fits & ~{1'b0, fits[NUM_COINS-1:1]};
    assign coin_avail  = fits[0];

    always_comb begin
        coin_value = 8'd0;
        for (int i = 0; i < NUM_COINS; i++) begin
            coin_value = coin_value | coin_term[i];
        end
    end

    assign remaining_after = remaining_reg - coin_value;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            remaining_reg    <= 8'd0;
            item_reg         <= 2'd0;
            insufficient_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            remaining_reg    <= remaining_next;
            item_reg         <= item_next;
            insufficient_reg <= insufficient_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        remaining_next    = remaining_reg;
        item_next         = item_reg;
        insufficient_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // A refund request blocks any selection made in the same
                // cycle, even when there is nothing to refund.
                if (cancel) begin
                    if (balance >= MIN_COIN) begin
                        remaining_next = balance;
                        state_next     = ST_CHANGE;
                    end
                end else if (select_valid) begin
                    remaining_next = balance;
                    item_next      = select;
                    state_next     = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (remaining_reg >= price_sel) begin
                    remaining_next = remaining_reg - price_sel;
                    state_next     = ST_DISPENSE;
                end else begin
                    // The rejection strobe is registered, so it appears one
                    // cycle later while the FSM is already back in IDLE.
                    // No clear is issued, so the customer keeps the credit.
                    insufficient_next = 1'b1;
                    state_next        = ST_IDLE;
                end
            end

            ST_DISPENSE: begin
                state_next = coin_avail ? ST_CHANGE : ST_CLEAR;
            end

            ST_CHANGE: begin
                if (!coin_avail) begin
                    // A residual below the smallest coin is forfeited.
                    state_next = ST_CLEAR;
                end else if (change_ack) begin
                    remaining_next = remaining_after;
                    if (remaining_after < MIN_COIN) begin
                        state_next = ST_CLEAR;
                    end
                end
            end

            ST_CLEAR: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Outputs depend on registers only; no input reaches an
    // output in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        busy          = (state_reg != ST_IDLE);
        dispense      = (state_reg == ST_DISPENSE);
        dispense_item = 2'd0;
        if (state_reg == ST_DISPENSE) begin
            dispense_item = item_reg;
        end
        insufficient  = insufficient_reg;
        change_valid  = (state_reg == ST_CHANGE) && coin_avail;
        change_coin   = 5'd0;
        if ((state_reg == ST_CHANGE) && coin_avail) begin
            change_coin = coin_onehot;
        end
        credit_clear  = (state_reg == ST_CLEAR);
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction stage directly downstream of the coin credit accumulator. Takes the accumulated `balance` and a product selection, checks the balance against a per-product price, and issues a one-cycle dispense strobe. It then pays out change (or a full refund on cancel) as a stream of coin codes using the same one-hot denominations the credit stage accepts, with a valid/ack handshake. Finally it pulses `credit_clear` so the credit stage zeroes its balance.

## Interface
- `PRICE0`, default 15: price of item 0, in currency units; multiple of 5, 0..255.
- `PRICE1`, default 25: price of item 1.
- `PRICE2`, default 50: price of item 2.
- `PRICE3`, default 100: price of item 3.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `balance`  in  8  current credit from the credit stage; unsigned.
- `select_valid`  in  1  one-cycle request to buy item `select`.
- `select`  in  2  item index 0..3.
- `cancel`  in  1  one-cycle refund request.
- `change_ack`  in  1  coin-return mechanism accepted the presented coin.
- `busy`  out  1  high in every state except IDLE; upstream gates coin acceptance with it.
- `dispense`  out  1  one-cycle strobe: release item `dispense_item`.
- `dispense_item`  out  2  item index; valid while `dispense` is high, else 0.
- `insufficient`  out  1  one-cycle strobe: the selection was rejected.
- `change_valid`  out  1  `change_coin` holds a coin to return.
- `change_coin`  out  5  one-hot coin code: 00001=5, 00010=10, 00100=20, 01000=50, 10000=100; 0 when not valid.
- `credit_clear`  out  1  one-cycle strobe: credit stage clears its balance.

## Operation
- States: IDLE, CHECK, DISPENSE, CHANGE, CLEAR. Outputs are decoded from registered state and registers only; there are no combinational input-to-output paths.
- Internal registers: `remaining` (8 bits) and `item` (2 bits).
- **IDLE**
  - `cancel` high with `balance` >= 5: load `remaining` <= `balance`, go to CHANGE.
  - `cancel` high with `balance` < 5: stay in IDLE, no output activity.
  - Otherwise, `select_valid` high: load `remaining` <= `balance` and `item` <= `select`, go to CHECK.
  - `cancel` has priority over `select_valid` when both are high in the same cycle.
- **CHECK** (always 1 cycle)
  - If `remaining` >= PRICE[`item`]: `remaining` <= `remaining` − PRICE[`item`], go to DISPENSE.
  - Otherwise: pulse `insufficient` for one cycle and return to IDLE. No `credit_clear` is issued, so the balance is kept.
  - Comparison and subtraction are 8-bit unsigned. No underflow is possible.
- **DISPENSE** (always 1 cycle)
  - `dispense` = 1 and `dispense_item` = `item`.
  - Next state is CHANGE if `remaining` >= 5, else CLEAR.
- **CHANGE**
  - Present the largest denomination <= `remaining` (greedy): `change_valid` = 1, `change_coin` = its code.
  - Any rising edge with `change_valid` and `change_ack` both high transfers one coin: `remaining` <= `remaining` − value.
  - After the transfer: if the new `remaining` < 5, go to CLEAR; otherwise present the next coin in the following cycle.
  - A residual below 5 is forfeited; it cannot occur with 5-multiple prices and credit.
- **CLEAR** (always 1 cycle)
  - `credit_clear` = 1, then return to IDLE.
- `select_valid` and `cancel` are ignored in every state other than IDLE.
- `balance` is sampled only on the IDLE accept edge; later changes are ignored.
- `change_ack` is ignored when `change_valid` is low.

## Timing
- Reset (`reset_n` low, asynchronous): state IDLE; `remaining` and `item` = 0; every output = 0, including `busy`. Reset mid-transaction abandons it and drops `change_valid` immediately. No `credit_clear` is issued.
- Select accepted in cycle N:
  - CHECK in N+1.
  - `dispense` or `insufficient` high in N+2.
  - With change: first `change_valid` in N+3. Exact price: `credit_clear` in N+3.
- Cancel accepted in cycle N: `change_valid` in N+1.
- Ack handshake:
  - `change_coin` is stable while `change_valid` is high and no ack has occurred, so ack may stall indefinitely.
  - After an ack in cycle M: the next coin appears in M+1 (`change_valid` may stay high back-to-back). If it was the last coin, `credit_clear` is high in M+1.
- `busy` rises the cycle after acceptance and falls the cycle after CLEAR.
- Every strobe (`dispense`, `insufficient`, `credit_clear`) is exactly one cycle wide.

## Test plan
- `balance`=40, select 1 (25), `change_ack` tied high → `dispense`/`dispense_item`=1 at N+2; coins 00010 then 00001 at N+3 and N+4; `credit_clear` at N+5; `busy` low at N+6.
- `balance`=20, select 2 (50) → `insufficient` at N+2; no `dispense`, no `change_valid`, no `credit_clear`; IDLE at N+3.
- `balance`=185, cancel, `change_ack` held low 3 cycles then high → 10000 held stable for 4 cycles, then 01000, 00100, 00010, 00001; one `credit_clear`; no `dispense`.
- `balance`=100, select 3 → `dispense` at N+2, no `change_valid`, `credit_clear` at N+3. Same-cycle `select_valid` and `cancel` with `balance`=30 → refund 20 then 10, no `dispense`.
- `select_valid` and `cancel` pulsed during CHANGE → ignored, coin sequence unchanged. `reset_n` low mid-CHANGE → all outputs 0 immediately; after release, IDLE and a new select works.
- Cancel with `balance`=0 → `busy` stays 0 and no output toggles.
